// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch: PC-driven opcode/immediate fetch with decoder handshake.    |
// | Optional one-instruction prefetch slot: INSTR_FETCH_PREFETCH_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_fetch (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic       o_pcNoe,
  output logic       o_pcIncr,
  output logic       o_memRead,
  input  logic [7:0] i_memData,
  input  logic       i_memReady,
  output logic [7:0] o_opcode,
  output logic [7:0] o_imm,
  output logic       o_valid,
  input  logic       i_ready,
  input  logic       i_flush
);

  typedef enum logic [1:0] {
    S_FETCH_OP  = 2'd0,
    S_FETCH_IMM = 2'd1,
    S_HOLD      = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] imm_q, imm_d;
  logic       w_mem_read;
  logic       w_pc_incr;

`ifdef INSTR_FETCH_PREFETCH_EN
  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_PART  = 2'd1,
    SLOT_FULL  = 2'd2
  } slot_t;

  slot_t      slot_q, slot_d;
  logic [7:0] slot_op_q, slot_op_d;
  logic [7:0] slot_imm_q, slot_imm_d;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_FETCH_OP;
      opcode_q   <= 8'h00;
      imm_q      <= 8'h00;
`ifdef INSTR_FETCH_PREFETCH_EN
      slot_q     <= SLOT_EMPTY;
      slot_op_q  <= 8'h00;
      slot_imm_q <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      imm_q      <= imm_d;
`ifdef INSTR_FETCH_PREFETCH_EN
      slot_q     <= slot_d;
      slot_op_q  <= slot_op_d;
      slot_imm_q <= slot_imm_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    imm_d      = imm_q;
    w_mem_read = 1'b0;
    w_pc_incr  = 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
    slot_d     = slot_q;
    slot_op_d  = slot_op_q;
    slot_imm_d = slot_imm_q;
`endif

    case (state_q)
      S_FETCH_OP: begin
        w_mem_read = 1'b1;
        if (i_memReady) begin
          w_pc_incr = 1'b1;
          opcode_d  = i_memData;
          imm_d     = 8'h00;
          state_d   = i_memData[7] ? S_FETCH_IMM : S_HOLD;
        end
      end
      S_FETCH_IMM: begin
        w_mem_read = 1'b1;
        if (i_memReady) begin
          w_pc_incr = 1'b1;
          imm_d     = i_memData;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
`ifdef INSTR_FETCH_PREFETCH_EN
        // Slot is filled first so a same-cycle acceptance sees the byte just read.
        w_mem_read = (slot_q != SLOT_FULL);
        if (w_mem_read && i_memReady) begin
          w_pc_incr = 1'b1;
          if (slot_q == SLOT_EMPTY) begin
            slot_op_d  = i_memData;
            slot_imm_d = 8'h00;
            slot_d     = i_memData[7] ? SLOT_PART : SLOT_FULL;
          end else begin
            slot_imm_d = i_memData;
            slot_d     = SLOT_FULL;
          end
        end
        if (i_ready) begin
          case (slot_d)
            SLOT_FULL: begin
              opcode_d = slot_op_d;
              imm_d    = slot_imm_d;
              slot_d   = SLOT_EMPTY;
            end
            SLOT_PART: begin
              opcode_d = slot_op_d;
              imm_d    = 8'h00;
              slot_d   = SLOT_EMPTY;
              state_d  = S_FETCH_IMM;
            end
            default: state_d = S_FETCH_OP;
          endcase
        end
`else
        if (i_ready) begin
          state_d = S_FETCH_OP;
        end
`endif
      end
      default: state_d = S_FETCH_OP;
    endcase

    // Flush wins over any same-cycle read completion or acceptance.
    if (i_flush) begin
      state_d   = S_FETCH_OP;
      opcode_d  = opcode_q;
      imm_d     = imm_q;
      w_pc_incr = 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
      slot_d    = SLOT_EMPTY;
`endif
    end

    if (i_reset) begin
      w_mem_read = 1'b0;
      w_pc_incr  = 1'b0;
    end
  end

  assign o_memRead = w_mem_read;
  assign o_pcNoe   = ~w_mem_read;
  assign o_pcIncr  = w_pc_incr;
  assign o_valid   = (state_q == S_HOLD) && !i_reset;
  assign o_opcode  = opcode_q;
  assign o_imm     = imm_q;

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit sitting directly downstream of the program counter. Drives the PC's output-enable and increment strobes, reads opcode and optional immediate bytes from the 8-bit program memory over a ready handshake, and presents complete instructions to the decoder with a valid/ready handshake. A flush input discards in-flight work after a taken jump or PC load.

## Interface
- No parameters; data and address width fixed at 8 bits.
- i_clk  in  1  system clock; all state changes on rising edge
- i_reset  in  1  synchronous, active-high reset
- o_pcNoe  out  1  active-low output enable for the PC onto the memory address bus
- o_pcIncr  out  1  one-cycle PC increment strobe; PC advances at the same clock edge
- o_memRead  out  1  memory read request; address is PC output
- i_memData  in  8  memory read data, valid when i_memReady=1
- i_memReady  in  1  read completes this cycle; low inserts wait states
- o_opcode  out  8  held opcode byte
- o_imm  out  8  held immediate byte; 0 for one-byte instructions
- o_valid  out  1  o_opcode/o_imm form a complete instruction
- i_ready  in  1  decoder accepts the instruction when o_valid && i_ready
- i_flush  in  1  discard all fetched/in-flight bytes; restart fetch next cycle

## Operation
- States: FETCH_OP, FETCH_IMM, HOLD.
- FETCH_OP: o_memRead=1, o_pcNoe=0. On i_memReady: opcode register <= i_memData, o_pcIncr=1 that cycle, imm register <= 0; next state FETCH_IMM if i_memData[7]=1, else HOLD.
- FETCH_IMM: o_memRead=1, o_pcNoe=0. On i_memReady: imm register <= i_memData, o_pcIncr=1, next HOLD.
- HOLD: o_valid=1, o_memRead=0, o_pcNoe=1. On i_ready: next FETCH_OP.
- o_pcIncr is combinational: state in {FETCH_OP, FETCH_IMM} && i_memReady && !i_flush && !i_reset. Never asserted without a completed read.
- o_pcNoe = !o_memRead.
- i_flush (any state): next state FETCH_OP, opcode/imm unchanged but o_valid=0 next cycle, no o_pcIncr this cycle, read data this cycle discarded. Flush dominates i_memReady and i_ready in the same cycle; a concurrent handshake does not count as accepted.
- Wait states: while i_memReady=0 the unit holds state and o_memRead; PC does not move.

## Timing
- Reset (i_reset=1 at edge): state FETCH_OP, opcode=0, imm=0, prefetch slot empty. While i_reset high, o_memRead=0, o_pcIncr=0, o_valid=0, o_pcNoe=1. First read issued the cycle after reset deasserts.
- Reset mid-operation aborts any fetch; no PC strobe in the reset cycle.
- One-byte instruction, zero wait states: read cycle N, o_valid in cycle N+1; minimum 2 cycles per instruction without prefetch.
- Two-byte instruction: reads in N, N+1, o_valid in N+2.
- o_opcode/o_imm stable while o_valid=1 and until acceptance.

## Configuration
- INSTR_FETCH_PREFETCH_EN defined: one-instruction prefetch slot. While in HOLD with slot empty and not accepted, unit keeps reading (o_memRead=1, o_pcIncr per byte) the next instruction into the slot. On acceptance with slot full, slot promotes to output and o_valid stays 1 the next cycle (zero bubble); with slot partially filled, fetch resumes at the missing byte. i_flush empties slot. In HOLD, o_memRead may be 1, so o_pcNoe follows o_memRead, not state.
- Not defined: no slot; behaviour exactly as in Operation, no reads in HOLD.

## Test plan
- Reset then memory {0x05} zero-wait, i_ready=1 -> one o_pcIncr pulse, o_valid cycle 2 after reset release with o_opcode=0x05, o_imm=0x00.
- Memory {0x83, 0x42}, i_memReady low 2 cycles before each byte -> o_memRead held, exactly 2 o_pcIncr pulses, o_opcode=0x83, o_imm=0x42.
- o_valid high with i_ready=0 for 5 cycles -> outputs stable, no o_pcIncr (macro off); with macro on, exactly the next instruction's bytes fetched, then stall.
- i_flush asserted same cycle as i_memReady during FETCH_IMM -> no o_pcIncr, o_valid=0, next cycle o_memRead=1 in FETCH_OP.
- i_reset asserted during wait state of FETCH_OP -> all outputs to reset values next cycle, no PC strobe.
- Macro on, stream {0x01,0x02,0x03}, i_ready=1 -> o_valid continuously high after first instruction, opcodes 0x01,0x02,0x03 on consecutive cycles.
